// File: rtl/link_error_collector_pkg.sv
/*
 * +--------------------------------------------------------------------+
 * | link_error_collector_pkg                                           |
 * | Word-count helper and collector FSM state encoding.                |
 * | Revision: 1.0                                                      |
 * +--------------------------------------------------------------------+
 */
`default_nettype none

package link_error_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } collector_state_e;

  function automatic int calc_num_words(input int num_links, input int out_width);
    return (num_links + out_width - 1) / out_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/parameters.sv
/*
 * +--------------------------------------------------------------------+
 * | parameters_pkg                                                     |
 * | Decoder stage codes broadcast on global_stage.                     |
 * | Revision: 1.0                                                      |
 * +--------------------------------------------------------------------+
 */
`default_nettype none

package parameters_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                  = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_PREPARING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING   = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                  = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE                 = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING               = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID          = 3'd6;

endpackage

`default_nettype wire

// File: rtl/link_error_collector_popcount_tree.sv
/*
 * +--------------------------------------------------------------------+
 * | popcount_tree                                                      |
 * | Combinational population count of a W-bit vector.                 |
 * | Revision: 1.0                                                      |
 * +--------------------------------------------------------------------+
 */
`default_nettype none

module popcount_tree #(
  parameter int W = 64
) (
  input  logic [W-1:0]             bits,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/link_error_collector.sv
/*
 * +--------------------------------------------------------------------+
 * | link_error_collector                                               |
 * | Snapshots masked link is_error bits on result entry and streams    |
 * | them out as words over valid/ready, with a total error count.      |
 * | Revision: 1.0                                                      |
 * +--------------------------------------------------------------------+
 */
`default_nettype none

module link_error_collector
  import link_error_collector_pkg::*;
  import parameters_pkg::*;
#(
  parameter int NUM_LINKS = 64,
  parameter int OUT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [STAGE_WIDTH-1:0]         global_stage,
  input  logic [NUM_LINKS-1:0]           link_is_error,
  input  logic [2*NUM_LINKS-1:0]         link_boundary_condition,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [$clog2(NUM_LINKS+1)-1:0] error_count,
  output logic                           busy,
  output logic                           overrun
);

  localparam int NUM_WORDS = calc_num_words(NUM_LINKS, OUT_WIDTH);
  localparam int PAD_W     = NUM_WORDS * OUT_WIDTH;
  localparam int CNT_W     = $clog2(NUM_LINKS + 1);
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BASE_W    = (PAD_W > 1) ? $clog2(PAD_W) : 1;

  collector_state_e          r_state;
  logic [STAGE_WIDTH-1:0]    r_last_stage;
  logic [PAD_W-1:0]          r_snapshot;
  logic [IDX_W-1:0]          r_idx;

  logic [NUM_LINKS-1:0]      w_masked;
  logic [PAD_W-1:0]          w_padded;
  logic [CNT_W-1:0]          w_pop;
  logic                      w_entry;
  logic [IDX_W-1:0]          w_next_idx;
  logic [BASE_W-1:0]         w_next_base;

  // Boundary condition values 2 and 3 mark an edge that does not exist.
  for (genvar i = 0; i < NUM_LINKS; i++) begin : g_mask
    assign w_masked[i] = link_is_error[i] & ~(link_boundary_condition[2*i +: 2] >= 2'd2);
  end

  assign w_padded    = PAD_W'(w_masked);
  assign w_entry     = (global_stage == STAGE_RESULT_VALID) && (r_last_stage != STAGE_RESULT_VALID);
  assign w_next_idx  = r_idx + 1'b1;
  assign w_next_base = BASE_W'(32'(w_next_idx) * OUT_WIDTH);

  popcount_tree #(.W(NUM_LINKS)) u_popcount (
    .bits  (w_masked),
    .count (w_pop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_stage <= STAGE_IDLE;
      r_snapshot   <= '0;
      r_idx        <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      error_count  <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      r_last_stage <= global_stage;

      case (r_state)
        ST_IDLE: begin
          if (w_entry) begin
            r_state <= ST_WAIT;
            busy    <= 1'b1;
          end
        end

        // Links present their is_error one clock after the stage change.
        ST_WAIT: begin
          r_snapshot  <= w_padded;
          error_count <= w_pop;
          out_data    <= w_padded[OUT_WIDTH-1:0];
          out_valid   <= 1'b1;
          out_last    <= (NUM_WORDS == 1);
          r_idx       <= '0;
          r_state     <= ST_SEND;
        end

        ST_SEND: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              r_state   <= ST_DONE;
            end else begin
              r_idx    <= w_next_idx;
              out_data <= r_snapshot[w_next_base +: OUT_WIDTH];
              out_last <= (w_next_idx == IDX_W'(NUM_WORDS - 1));
            end
          end
        end

        ST_DONE: begin
          r_idx <= '0;
          if (global_stage != STAGE_RESULT_VALID) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase

      if (w_entry && (r_state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_link_error_collector.sv
/*
 * +--------------------------------------------------------------------+
 * | tb_link_error_collector                                            |
 * | Self-checking bench for link_error_collector (64x8 and 20x8).      |
 * | Revision: 1.0                                                      |
 * +--------------------------------------------------------------------+
 */
`default_nettype none

module tb_link_error_collector;
  import parameters_pkg::*;

  logic clk = 1'b0;
  logic reset;

  logic [STAGE_WIDTH-1:0] stage_a, stage_b;
  logic [63:0]  err_a;
  logic [127:0] bc_a;
  logic         ready_a;
  logic [7:0]   data_a;
  logic         valid_a, last_a, busy_a, ovr_a;
  logic [6:0]   cnt_a;

  logic [19:0]  err_b;
  logic [39:0]  bc_b;
  logic         ready_b;
  logic [7:0]   data_b;
  logic         valid_b, last_b, busy_b, ovr_b;
  logic [4:0]   cnt_b;

  int checks = 0;
  int errors = 0;
  bit exp_ovr = 1'b0;

  always #5 clk = ~clk;

  link_error_collector #(.NUM_LINKS(64), .OUT_WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .global_stage(stage_a),
    .link_is_error(err_a), .link_boundary_condition(bc_a),
    .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .out_last(last_a),
    .error_count(cnt_a), .busy(busy_a), .overrun(ovr_a)
  );

  link_error_collector #(.NUM_LINKS(20), .OUT_WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .global_stage(stage_b),
    .link_is_error(err_b), .link_boundary_condition(bc_b),
    .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .out_last(last_b),
    .error_count(cnt_b), .busy(busy_b), .overrun(ovr_b)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a link counts when it reports an error and its boundary value is below 2.
  function automatic void model(input logic [63:0] err, input logic [127:0] bc,
                                output logic [63:0] bits, output int cnt);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      int bcv;
      bcv = int'(bc[2*i +: 2]);
      bits[i] = err[i] && (bcv < 2);
      cnt += int'(bits[i]);
    end
  endfunction

  // rmode: 0 ready always, 1 alternating, 2 random. disturb_at: word count at which the
  // stage briefly leaves and re-enters RESULT_VALID (-1 for none).
  task automatic run_round(input logic [63:0] err, input logic [127:0] bc,
                           input logic [63:0] exp_bits, input int exp_cnt,
                           input int rmode, input int disturb_at, input string nm);
    logic [7:0] got[$];
    logic [7:0] prev_data;
    logic       prev_stall, r, done;
    int         first_valid, last_cyc, dphase;
    err_a = err; bc_a = bc; stage_a = STAGE_RESULT_VALID; ready_a = 1'b1;
    @(negedge clk);
    check({nm, " busy_after_entry"}, 64'(busy_a), 64'd1);
    check({nm, " no_valid_in_wait"}, 64'(valid_a), 64'd0);
    prev_stall = 1'b0; prev_data = '0; done = 1'b0;
    first_valid = -1; last_cyc = -1; dphase = 0;
    for (int cyc = 1; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      if (dphase == 1) begin
        stage_a = STAGE_RESULT_VALID;
        dphase  = 2;
      end
      if (valid_a) begin
        if (first_valid < 0) first_valid = cyc;
        if (prev_stall) check({nm, " stable_data"}, 64'(data_a), 64'(prev_data));
        case (rmode)
          0:       r = 1'b1;
          1:       r = (cyc % 2 == 0);
          default: r = ($urandom_range(0, 3) != 0);
        endcase
        ready_a = r;
        if (dphase == 0 && disturb_at >= 0 && got.size() == disturb_at) begin
          stage_a = STAGE_IDLE;
          err_a   = ~err;
          dphase  = 1;
        end
        if (r) begin
          got.push_back(data_a);
          check({nm, " last_flag"}, 64'(last_a), 64'(got.size() == 8));
          if (last_a) begin
            done = 1'b1;
            last_cyc = cyc;
          end
        end
        prev_stall = !r;
        prev_data  = data_a;
      end else begin
        prev_stall = 1'b0;
      end
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL %s timeout: got %0d words expected 8", nm, got.size());
    end
    ready_a = 1'b1;
    check({nm, " word_count"}, 64'(got.size()), 64'd8);
    for (int k = 0; k < got.size() && k < 8; k++) begin
      check($sformatf("%s word%0d", nm, k), 64'(got[k]), 64'(exp_bits[k*8 +: 8]));
    end
    check({nm, " error_count"}, 64'(cnt_a), 64'(exp_cnt));
    if (rmode == 0 && disturb_at < 0) begin
      check({nm, " first_valid_cycle"}, 64'(first_valid), 64'd1);
      check({nm, " last_cycle"}, 64'(last_cyc), 64'd8);
    end
    @(negedge clk);
    check({nm, " done_valid_low"}, 64'(valid_a), 64'd0);
    check({nm, " done_busy"}, 64'(busy_a), 64'd1);
    stage_a = STAGE_IDLE;
    @(negedge clk);
    check({nm, " idle_busy"}, 64'(busy_a), 64'd0);
    check({nm, " overrun"}, 64'(ovr_a), 64'(exp_ovr));
    check({nm, " count_held"}, 64'(cnt_a), 64'(exp_cnt));
  endtask

  typedef struct {
    logic [63:0]  err;
    logic [127:0] bc;
    logic [63:0]  exp_bits;
    int           exp_cnt;
    int           rmode;
    string        name;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [63:0] mbits;
    int          mcnt;
    logic [7:0]  exp_b[3];
    logic [7:0]  got_b[$];
    bit          doneb;
    int          n;

    vecs[0] = '{64'h8000_0000_0000_0201, 128'h0, 64'h8000_0000_0000_0201, 3, 0, "basic"};
    vecs[1] = '{64'h8000_0000_0000_0201, 128'h8_0000, 64'h8000_0000_0000_0001, 2, 0, "bc_mask"};
    vecs[2] = '{64'h8000_0000_0000_0201, 128'h0, 64'h8000_0000_0000_0201, 3, 1, "backpressure"};
    vecs[3] = '{{64{1'b1}}, {128{1'b1}}, 64'h0, 0, 0, "all_nonexist"};
    vecs[4] = '{{64{1'b1}}, 128'h0, {64{1'b1}}, 64, 1, "all_err"};
    vecs[5] = '{64'hF0F0_0000_FFFF_1234, {64{2'b01}}, 64'hF0F0_0000_FFFF_1234, 29, 0, "bc1_kept"};
    vecs[6] = '{{64{1'b1}}, {32{4'h8}}, 64'h5555_5555_5555_5555, 32, 0, "odd_masked"};
    exp_b = '{8'hFF, 8'hFF, 8'h0F};

    reset = 1'b1;
    stage_a = STAGE_IDLE; err_a = '0; bc_a = '0; ready_a = 1'b1;
    stage_b = STAGE_IDLE; err_b = '0; bc_b = '0; ready_b = 1'b1;
    repeat (3) @(negedge clk);
    check("reset out_valid", 64'(valid_a), 64'd0);
    check("reset out_data", 64'(data_a), 64'd0);
    check("reset out_last", 64'(last_a), 64'd0);
    check("reset error_count", 64'(cnt_a), 64'd0);
    check("reset busy", 64'(busy_a), 64'd0);
    check("reset overrun", 64'(ovr_a), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle stays idle", 64'(busy_a), 64'd0);

    for (int v = 0; v < 7; v++) begin
      run_round(vecs[v].err, vecs[v].bc, vecs[v].exp_bits, vecs[v].exp_cnt,
                vecs[v].rmode, -1, vecs[v].name);
    end

    for (int t = 0; t < 15; t++) begin
      logic [63:0]  rerr;
      logic [127:0] rbc;
      rerr = {$urandom, $urandom};
      rbc  = {$urandom, $urandom, $urandom, $urandom};
      model(rerr, rbc, mbits, mcnt);
      run_round(rerr, rbc, mbits, mcnt, 2, -1, $sformatf("rand%0d", t));
    end

    // Narrow instance: 20 links padded into three words.
    err_b = '1; bc_b = '0; stage_b = STAGE_RESULT_VALID; ready_b = 1'b1;
    @(negedge clk);
    doneb = 1'b0;
    for (int c = 0; c < 12 && !doneb; c++) begin
      @(negedge clk);
      if (valid_b) begin
        got_b.push_back(data_b);
        check("narrow last_flag", 64'(last_b), 64'(got_b.size() == 3));
        if (last_b) doneb = 1'b1;
      end
    end
    check("narrow word_count", 64'(got_b.size()), 64'd3);
    for (int k = 0; k < got_b.size() && k < 3; k++) begin
      check($sformatf("narrow word%0d", k), 64'(got_b[k]), 64'(exp_b[k]));
    end
    check("narrow error_count", 64'(cnt_b), 64'd20);
    stage_b = STAGE_IDLE;

    // Stage re-entry mid-stream must not disturb the captured snapshot.
    exp_ovr = 1'b1;
    run_round(vecs[0].err, vecs[0].bc, vecs[0].exp_bits, vecs[0].exp_cnt, 0, 2, "reentry");
    repeat (2) @(negedge clk);
    check("overrun sticky", 64'(ovr_a), 64'd1);

    // Reset while word 3 is presented.
    err_a = 64'h0123_4567_89AB_CDEF; bc_a = '0; stage_a = STAGE_RESULT_VALID; ready_a = 1'b1;
    @(negedge clk);
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (valid_a) n++;
    end
    if (n < 3) begin
      errors++; checks++;
      $display("FAIL midreset timeout: got %0d words expected 3", n);
    end
    @(negedge clk);
    check("midreset word3", 64'(data_a), 64'h89);
    reset = 1'b1;
    stage_a = STAGE_IDLE;
    @(negedge clk);
    check("midreset out_valid", 64'(valid_a), 64'd0);
    check("midreset busy", 64'(busy_a), 64'd0);
    check("midreset error_count", 64'(cnt_a), 64'd0);
    check("midreset overrun", 64'(ovr_a), 64'd0);
    check("midreset out_last", 64'(last_a), 64'd0);
    reset = 1'b0;
    exp_ovr = 1'b0;
    @(negedge clk);
    run_round(vecs[1].err, vecs[1].bc, vecs[1].exp_bits, vecs[1].exp_cnt, 0, -1, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
